if_stage: RTL and testbench

//  Instruction-fetch stage between the program counter and decode in the 5-stage pipeline.
//  - Computes next-PC (sequential / branch / jump / jr) and drives the PC's PCin/PCWrite.
//  - Registers fetched instruction + PC+4 into the IF/ID pipeline register.
//  - Handles load-use stalls, redirect flushes, and a performance counter.

---
 rtl/if_stage_pkg.sv | 12 +
 rtl/if_stage_next_pc_sel.sv | 34 +++
 rtl/if_stage.sv | 86 ++++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage: NOP encoding, fetch FSM states, PC step.
package if_stage_pkg;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam int          PC_INC = 4;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_stage_next_pc_sel.sv
// Next-PC priority mux (jr > jump > branch > pc+4) plus the pc+4 adder; purely combinational.
// Zero latency, no backpressure: stall gating is applied by the caller.
module next_pc_sel
   import if_stage_pkg::*;
#(
   parameter int PC_W = 18
) (
   input  logic [PC_W-1:0] pc_cur,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_target,
   output logic [PC_W-1:0] pc4,
   output logic [PC_W-1:0] pc_sel,
   output logic            redirect
);

   // Adder truncates to PC_W, so the top word wraps to address zero.
   assign pc4      = pc_cur + PC_W'(PC_INC);
   assign redirect = jr | jump | br_taken;

   always_comb begin
      pc_sel = pc4;
      if (jr)
         pc_sel = jr_target;
      else if (jump)
         pc_sel = jump_target;
      else if (br_taken)
         pc_sel = br_target;
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: drives PC update and loads the IF/ID register; one-cycle latency to ifid_*.
// Stall holds PC and IF/ID; a redirect squashes the wrong-path fetch with a bubble.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int PC_W    = 18,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_W-1:0]    pc_cur,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [PC_W-1:0]    br_target,
   input  logic               jump,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               jr,
   input  logic [PC_W-1:0]    jr_target,
   output logic [PC_W-1:0]    pc_next,
   output logic               pc_write,
   output logic [PC_W-1:0]    ifid_pc4,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic               ifid_valid,
   output logic [CNT_W-1:0]   fetch_cnt
);

   logic [PC_W-1:0] pc4;
   logic [PC_W-1:0] pc_sel;
   logic            redirect;
   fetch_state_t    state_q;
   fetch_state_t    state_d;

   next_pc_sel #(
      .PC_W (PC_W)
   ) u_next_pc_sel (
      .pc_cur      (pc_cur),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .jr          (jr),
      .jr_target   (jr_target),
      .pc4         (pc4),
      .pc_sel      (pc_sel),
      .redirect    (redirect)
   );

   // During reset the PC is forced to zero; a stalled redirect is simply not written.
   assign pc_next  = rst ? '0 : pc_sel;
   assign pc_write = rst | ~stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_pc4   <= '0;
         ifid_instr <= INSTR_W'(NOP);
         ifid_valid <= 1'b0;
         fetch_cnt  <= '0;
      end else if (!stall) begin
         if (redirect) begin
            ifid_instr <= INSTR_W'(NOP);
            ifid_valid <= 1'b0;
         end else begin
            ifid_instr <= instr_in;
            ifid_pc4   <= pc4;
            ifid_valid <= 1'b1;
            fetch_cnt  <= fetch_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!stall)
         state_d = redirect ? FLUSH : RUN;
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, redirect priority, wrap, mid-stall reset.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam int PC_W    = 18;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [PC_W-1:0]    pc_cur;
   logic [INSTR_W-1:0] instr_in;
   logic               stall;
   logic               br_taken;
   logic [PC_W-1:0]    br_target;
   logic               jump;
   logic [PC_W-1:0]    jump_target;
   logic               jr;
   logic [PC_W-1:0]    jr_target;
   logic [PC_W-1:0]    pc_next;
   logic               pc_write;
   logic [PC_W-1:0]    ifid_pc4;
   logic [INSTR_W-1:0] ifid_instr;
   logic               ifid_valid;
   logic [CNT_W-1:0]   fetch_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_stage #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_cur      (pc_cur),
      .instr_in    (instr_in),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .jr          (jr),
      .jr_target   (jr_target),
      .pc_next     (pc_next),
      .pc_write    (pc_write),
      .ifid_pc4    (ifid_pc4),
      .ifid_instr  (ifid_instr),
      .ifid_valid  (ifid_valid),
      .fetch_cnt   (fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc4_e, input logic [31:0] instr_e,
                           input logic valid_e, input logic [31:0] cnt_e);
      chk({tag, ".pc4"},   32'(ifid_pc4),   pc4_e);
      chk({tag, ".instr"}, ifid_instr,      instr_e);
      chk({tag, ".valid"}, 32'(ifid_valid), 32'(valid_e));
      chk({tag, ".cnt"},   fetch_cnt,       cnt_e);
   endtask

   initial begin
      rst = 1'b1; pc_cur = 18'h100; instr_in = 32'h0; stall = 1'b0;
      br_taken = 1'b0; br_target = 18'h0C0;
      jump = 1'b0; jump_target = 18'h080;
      jr = 1'b0; jr_target = 18'h040;

      // Reset held for two cycles
      #1;
      chk("rst.pc_next", 32'(pc_next), 32'h0);
      chk("rst.pc_write", 32'(pc_write), 32'h1);
      tick();
      tick();
      chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'd0);
      chk("rst.state", 32'(dut.state_q), 32'(RUN));

      // Plain sequential fetch
      rst = 1'b0; instr_in = 32'h8C01_0004;
      #1;
      chk("seq.pc_next", 32'(pc_next), 32'h104);
      chk("seq.pc_write", 32'(pc_write), 32'h1);
      tick();
      chk_ifid("seq", 32'h104, 32'h8C01_0004, 1'b1, 32'd1);

      // Two stalled cycles hold everything
      pc_cur = 18'h104; instr_in = 32'h1111_1111; stall = 1'b1;
      #1;
      chk("stall.pc_write", 32'(pc_write), 32'h0);
      tick();
      tick();
      chk_ifid("stall", 32'h104, 32'h8C01_0004, 1'b1, 32'd1);
      stall = 1'b0;
      #1;
      chk("unstall.pc_next", 32'(pc_next), 32'h108);
      chk("unstall.pc_write", 32'(pc_write), 32'h1);
      tick();
      chk_ifid("unstall", 32'h108, 32'h1111_1111, 1'b1, 32'd2);

      // All three redirects: jr wins
      pc_cur = 18'h108; instr_in = 32'h2222_2222; jr = 1'b1; jump = 1'b1; br_taken = 1'b1;
      #1;
      chk("jr.pc_next", 32'(pc_next), 32'h040);
      tick();
      chk_ifid("jr", 32'h108, 32'h0, 1'b0, 32'd2);
      chk("jr.state", 32'(dut.state_q), 32'(FLUSH));

      // Back-to-back redirect: jump beats branch, stays FLUSH
      pc_cur = 18'h040; instr_in = 32'h5555_5555; jr = 1'b0;
      #1;
      chk("jmp.pc_next", 32'(pc_next), 32'h080);
      tick();
      chk_ifid("jmp", 32'h108, 32'h0, 1'b0, 32'd2);
      chk("jmp.state", 32'(dut.state_q), 32'(FLUSH));

      // Stall with branch pending: no flush, state held
      pc_cur = 18'h080; jump = 1'b0; stall = 1'b1;
      #1;
      chk("stbr.pc_write", 32'(pc_write), 32'h0);
      tick();
      chk_ifid("stbr", 32'h108, 32'h0, 1'b0, 32'd2);
      chk("stbr.state", 32'(dut.state_q), 32'(FLUSH));
      stall = 1'b0;
      #1;
      chk("br.pc_next", 32'(pc_next), 32'h0C0);
      chk("br.pc_write", 32'(pc_write), 32'h1);
      tick();
      chk_ifid("br", 32'h108, 32'h0, 1'b0, 32'd2);

      // Leave FLUSH on a clean fetch at the branch target
      pc_cur = 18'h0C0; instr_in = 32'h3333_3333; br_taken = 1'b0;
      #1;
      chk("tgt.pc_next", 32'(pc_next), 32'h0C4);
      tick();
      chk_ifid("tgt", 32'h0C4, 32'h3333_3333, 1'b1, 32'd3);
      chk("tgt.state", 32'(dut.state_q), 32'(RUN));

      // PC wrap at top of address space
      pc_cur = 18'h3FFFC; instr_in = 32'h4444_4444;
      #1;
      chk("wrap.pc_next", 32'(pc_next), 32'h0);
      tick();
      chk_ifid("wrap", 32'h0, 32'h4444_4444, 1'b1, 32'd4);

      // Reset asserted in the middle of a stalled redirect
      pc_cur = 18'h200; stall = 1'b1; jr = 1'b1; rst = 1'b1;
      #1;
      chk("mrst.pc_next", 32'(pc_next), 32'h0);
      chk("mrst.pc_write", 32'(pc_write), 32'h1);
      tick();
      chk_ifid("mrst", 32'h0, 32'h0, 1'b0, 32'd0);
      chk("mrst.state", 32'(dut.state_q), 32'(RUN));

      rst = 1'b0; stall = 1'b0; jr = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
